// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared constants and helpers for the CNN datapath
package cnn_pkg;

    localparam int DATA_W_DEF = 16;

    // Minimum width of 1 so single-entry dimensions still get a real counter.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int tap_lo(input int j, input int w);
        return j * w;
    endfunction

endpackage

// File: rtl/window_line_buffer_if.sv
// rtl/window_line_buffer_if.sv - pixel-in / tap-column-out bundle
interface window_line_buffer_if #(
    parameter int DATA_W = cnn_pkg::DATA_W_DEF,
    parameter int K      = 5,
    parameter int MAP_W  = 28,
    parameter int MAP_H  = 28
);
    import cnn_pkg::*;

    localparam int ROW_W = clog2(MAP_H);
    localparam int COL_W = clog2(MAP_W);

    logic [DATA_W-1:0]   d_in;
    logic                in_valid;
    logic                in_sof;
    logic [K*DATA_W-1:0] d_out;
    logic                out_valid;
    logic [ROW_W-1:0]    out_row;
    logic [COL_W-1:0]    out_col;
    logic                out_sow;
    logic                out_eof;

    modport master (
        output d_in, in_valid, in_sof,
        input  d_out, out_valid, out_row, out_col, out_sow, out_eof
    );

    modport slave (
        input  d_in, in_valid, in_sof,
        output d_out, out_valid, out_row, out_col, out_sow, out_eof
    );

endinterface

// File: rtl/line_mem.sv
// rtl/line_mem.sv - single-port read-before-write row store, no reset
module line_mem #(
    parameter int DEPTH  = 28,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Asynchronous read returns the pre-write word; the caller registers it.
    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

endmodule

// File: rtl/window_line_buffer.sv
// rtl/window_line_buffer.sv - K-row line buffer emitting aligned tap columns
module window_line_buffer
    import cnn_pkg::*;
#(
    parameter int MAP_W    = 28,
    parameter int MAP_H    = 28,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int K        = 5,
    parameter int COL_GATE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    window_line_buffer_if.slave  bus
);

    localparam int ROW_W = clog2(MAP_H);
    localparam int COL_W = clog2(MAP_W);

    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(MAP_H - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(MAP_W - 1);
    localparam logic [ROW_W-1:0] ROW_TAPS  = ROW_W'(K - 1);
    localparam logic [COL_W-1:0] COL_TAPS  = COL_W'(K - 1);
    localparam logic [COL_W-1:0] SOW_COL   = (COL_GATE != 0) ? COL_W'(K - 1) : '0;

    logic [COL_W-1:0]    col, col_eff, col_nxt;
    logic [ROW_W-1:0]    row, row_eff, row_nxt;
    logic [DATA_W-1:0]   rd [K-1];
    logic [DATA_W-1:0]   wd [K-1];
    logic [K*DATA_W-1:0] tap;
    logic                col_ok, win_ok, sow_hit, eof_hit;

    // A start-of-frame beat is position (0,0) regardless of the counters.
    assign col_eff = bus.in_sof ? '0 : col;
    assign row_eff = bus.in_sof ? '0 : row;

    generate
        for (genvar j = 0; j < K - 1; j++) begin : g_line
            if (j == K - 2) begin : g_top
                assign wd[j] = bus.d_in;
            end else begin : g_shift
                assign wd[j] = rd[j+1];
            end
            line_mem #(
                .DEPTH  (MAP_W),
                .DATA_W (DATA_W),
                .ADDR_W (COL_W)
            ) u_mem (
                .clk   (clk),
                .we    (bus.in_valid),
                .addr  (col_eff),
                .wdata (wd[j]),
                .rdata (rd[j])
            );
        end
    endgenerate

    always_comb begin
        tap = '0;
        for (int j = 0; j < K - 1; j++) begin
            tap[tap_lo(j, DATA_W) +: DATA_W] = rd[j];
        end
        tap[tap_lo(K - 1, DATA_W) +: DATA_W] = bus.d_in;
    end

    always_comb begin
        col_nxt = col_eff;
        row_nxt = row_eff;
        if (col_eff == COL_LAST) begin
            col_nxt = '0;
            row_nxt = (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
        end else begin
            col_nxt = col_eff + 1'b1;
        end
    end

    assign col_ok  = (COL_GATE == 0) || (col_eff >= COL_TAPS);
    assign win_ok  = (row_eff >= ROW_TAPS) && col_ok;
    assign sow_hit = (row_eff == ROW_TAPS) && (col_eff == SOW_COL);
    assign eof_hit = (row_eff == ROW_LAST) && (col_eff == COL_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            col           <= '0;
            row           <= '0;
            bus.d_out     <= '0;
            bus.out_valid <= 1'b0;
            bus.out_row   <= '0;
            bus.out_col   <= '0;
            bus.out_sow   <= 1'b0;
            bus.out_eof   <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            bus.out_sow   <= 1'b0;
            bus.out_eof   <= 1'b0;
            if (bus.in_valid) begin
                col           <= col_nxt;
                row           <= row_nxt;
                bus.d_out     <= tap;
                bus.out_row   <= row_eff;
                bus.out_col   <= col_eff;
                bus.out_valid <= win_ok;
                bus.out_sow   <= win_ok && sow_hit;
                bus.out_eof   <= eof_hit;
            end
        end
    end

endmodule

// File: tb/tb_window_line_buffer.sv
// tb/tb_window_line_buffer.sv - randomized bench for window_line_buffer against a frame-image model
module tb_window_line_buffer;
    import cnn_pkg::*;

    localparam int MW = 5;
    localparam int MH = 5;
    localparam int DW = 8;
    localparam int KK = 3;
    localparam int FW = KK * DW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    window_line_buffer_if #(.DATA_W(DW), .K(KK), .MAP_W(MW), .MAP_H(MH)) bus0 ();
    window_line_buffer_if #(.DATA_W(DW), .K(KK), .MAP_W(MW), .MAP_H(MH)) bus1 ();

    window_line_buffer #(.MAP_W(MW), .MAP_H(MH), .DATA_W(DW), .K(KK), .COL_GATE(0)) dut0 (
        .clk (clk), .rst (rst), .bus (bus0)
    );
    window_line_buffer #(.MAP_W(MW), .MAP_H(MH), .DATA_W(DW), .K(KK), .COL_GATE(1)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );

    int checks = 0;
    int errors = 0;

    // Model: image of pixels written since the last origin, plus raster position.
    logic [DW-1:0] pix [MH][MW];
    int            mrow, mcol;
    logic [FW-1:0] e_full;
    bit            full_known;
    int            e_row, e_col;
    logic [DW-1:0] e_top;

    int            vcount [2];
    bit            got_first [2];
    logic [FW-1:0] first_win [2];
    int            first_acc [2];
    int            first_row [2];
    int            first_col [2];
    logic [FW-1:0] eof_win [2];
    int            acc_count;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        acc_count = 0;
        for (int g = 0; g < 2; g++) begin
            vcount[g]    = 0;
            got_first[g] = 0;
            first_win[g] = '0;
            first_acc[g] = 0;
            first_row[g] = -1;
            first_col[g] = -1;
            eof_win[g]   = '0;
        end
    endtask

    task automatic step(input bit v, input bit sof, input logic [DW-1:0] d, input bit r = 1'b0);
        int            er, ec;
        bit            ev, esow, eeof;
        logic [FW-1:0] ef;
        logic [FW-1:0] o_dout;
        logic          o_valid, o_sow, o_eof;
        int            o_row, o_col;
        @(negedge clk);
        rst = r;
        bus0.in_valid = v; bus0.in_sof = sof; bus0.d_in = d;
        bus1.in_valid = v; bus1.in_sof = sof; bus1.d_in = d;
        er = sof ? 0 : mrow;
        ec = sof ? 0 : mcol;
        eeof = (er == MH - 1) && (ec == MW - 1);
        ef = '0;
        if (er >= KK - 1) begin
            for (int j = 0; j < KK - 1; j++) ef[j*DW +: DW] = pix[er-(KK-1)+j][ec];
            ef[(KK-1)*DW +: DW] = d;
        end
        @(posedge clk);
        #1;
        if (v && !r) acc_count++;
        for (int g = 0; g < 2; g++) begin
            o_dout  = g ? bus1.d_out     : bus0.d_out;
            o_valid = g ? bus1.out_valid : bus0.out_valid;
            o_sow   = g ? bus1.out_sow   : bus0.out_sow;
            o_eof   = g ? bus1.out_eof   : bus0.out_eof;
            o_row   = int'(g ? bus1.out_row : bus0.out_row);
            o_col   = int'(g ? bus1.out_col : bus0.out_col);
            if (r) begin
                chk($sformatf("rst_dout_g%0d", g),  64'(o_dout), 64'd0);
                chk($sformatf("rst_valid_g%0d", g), 64'(o_valid), 64'd0);
                chk($sformatf("rst_row_g%0d", g),   64'(o_row), 64'd0);
                chk($sformatf("rst_col_g%0d", g),   64'(o_col), 64'd0);
                chk($sformatf("rst_sow_g%0d", g),   64'(o_sow), 64'd0);
                chk($sformatf("rst_eof_g%0d", g),   64'(o_eof), 64'd0);
            end else if (v) begin
                ev   = (er >= KK - 1) && (g == 0 || ec >= KK - 1);
                esow = ev && (er == KK - 1) && (ec == (g ? KK - 1 : 0));
                chk($sformatf("valid_g%0d_r%0d_c%0d", g, er, ec), 64'(o_valid), 64'(ev));
                chk($sformatf("sow_g%0d_r%0d_c%0d", g, er, ec),   64'(o_sow), 64'(esow));
                chk($sformatf("eof_g%0d_r%0d_c%0d", g, er, ec),   64'(o_eof), 64'(eeof));
                chk($sformatf("row_g%0d", g), 64'(o_row), 64'(er));
                chk($sformatf("col_g%0d", g), 64'(o_col), 64'(ec));
                chk($sformatf("top_g%0d", g), 64'(o_dout[(KK-1)*DW +: DW]), 64'(d));
                if (er >= KK - 1)
                    chk($sformatf("win_g%0d_r%0d_c%0d", g, er, ec), 64'(o_dout), 64'(ef));
                if (ev) begin
                    vcount[g]++;
                    if (!got_first[g]) begin
                        got_first[g] = 1;
                        first_win[g] = o_dout;
                        first_acc[g] = acc_count;
                        first_row[g] = o_row;
                        first_col[g] = o_col;
                    end
                end
                if (eeof) eof_win[g] = o_dout;
            end else begin
                chk($sformatf("idle_valid_g%0d", g), 64'(o_valid), 64'd0);
                chk($sformatf("idle_sow_g%0d", g),   64'(o_sow), 64'd0);
                chk($sformatf("idle_eof_g%0d", g),   64'(o_eof), 64'd0);
                chk($sformatf("hold_row_g%0d", g),   64'(o_row), 64'(e_row));
                chk($sformatf("hold_col_g%0d", g),   64'(o_col), 64'(e_col));
                chk($sformatf("hold_top_g%0d", g),   64'(o_dout[(KK-1)*DW +: DW]), 64'(e_top));
                if (full_known) chk($sformatf("hold_win_g%0d", g), 64'(o_dout), 64'(e_full));
            end
        end
        if (r) begin
            mrow = 0; mcol = 0;
            e_full = '0; full_known = 1; e_row = 0; e_col = 0; e_top = '0;
        end else if (v) begin
            pix[er][ec] = d;
            e_row = er; e_col = ec; e_top = d;
            e_full = ef; full_known = (er >= KK - 1);
            if (ec == MW - 1) begin
                mcol = 0;
                mrow = (er == MH - 1) ? 0 : er + 1;
            end else begin
                mcol = ec + 1;
                mrow = er;
            end
        end
    endtask

    task automatic idle_gaps(input int pct);
        int n;
        n = 0;
        while (int'($urandom_range(0, 99)) < pct && n < 6) begin
            step(1'b0, 1'b0, DW'($urandom_range(0, 255)));
            n++;
        end
    endtask

    task automatic run_frame(input int base, input int pct);
        for (int r = 0; r < MH; r++) begin
            for (int c = 0; c < MW; c++) begin
                idle_gaps(pct);
                step(1'b1, 1'b0, DW'(base + r * 16 + c));
            end
        end
    endtask

    initial begin
        bus0.in_valid = 0; bus0.in_sof = 0; bus0.d_in = '0;
        bus1.in_valid = 0; bus1.in_sof = 0; bus1.d_in = '0;
        mrow = 0; mcol = 0; full_known = 0; e_full = '0; e_row = 0; e_col = 0; e_top = '0;
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h5A, 1'b1);

        // Continuous frame, pixel = row*16+col
        clear_stats();
        run_frame(0, 0);
        chk("first_win_gate1", 64'(first_win[1]), 64'h221202);
        chk("first_win_gate0", 64'(first_win[0]), 64'h201000);
        chk("vcount_gate1", 64'(vcount[1]), 64'd9);
        chk("vcount_gate0", 64'(vcount[0]), 64'd15);
        chk("eof_win_gate1", 64'(eof_win[1]), 64'h443424);
        chk("eof_win_gate0", 64'(eof_win[0]), 64'h443424);

        // Same frame with ~40% idle cycles
        clear_stats();
        run_frame(0, 40);
        chk("gap_first_win", 64'(first_win[1]), 64'h221202);
        chk("gap_vcount_gate1", 64'(vcount[1]), 64'd9);
        chk("gap_vcount_gate0", 64'(vcount[0]), 64'd15);

        // Back-to-back frame with +0x80 values; rows 0-1 must stay silent
        clear_stats();
        run_frame(8'h80, 0);
        chk("f2_first_win", 64'(first_win[1]), 64'hA29282);
        chk("f2_first_acc", 64'(first_acc[1]), 64'd13);
        chk("f2_vcount_gate1", 64'(vcount[1]), 64'd9);

        // Random data, re-sync with in_sof at (3,1)
        clear_stats();
        for (int n = 0; n < 40 && !(mrow == 3 && mcol == 1); n++) begin
            idle_gaps(30);
            step(1'b1, 1'b0, DW'($urandom_range(0, 255)));
        end
        chk("sof_reach_row", 64'(mrow), 64'd3);
        chk("sof_reach_col", 64'(mcol), 64'd1);
        clear_stats();
        step(1'b1, 1'b1, DW'($urandom_range(0, 255)));
        for (int n = 0; n < 30; n++) begin
            idle_gaps(30);
            step(1'b1, 1'b0, DW'($urandom_range(0, 255)));
        end
        chk("sof_first_row", 64'(first_row[1]), 64'd2);
        chk("sof_first_col", 64'(first_col[1]), 64'd2);

        // Reset pulse at (3,3), then 15 accepts
        for (int n = 0; n < 40 && !(mrow == 3 && mcol == 3); n++)
            step(1'b1, 1'b0, DW'($urandom_range(0, 255)));
        chk("rst_reach_row", 64'(mrow), 64'd3);
        chk("rst_reach_col", 64'(mcol), 64'd3);
        step(1'b1, 1'b0, DW'($urandom_range(0, 255)), 1'b1);
        clear_stats();
        for (int n = 0; n < 15; n++) begin
            idle_gaps(20);
            step(1'b1, 1'b0, DW'($urandom_range(0, 255)));
        end
        chk("rst_first_acc", 64'(first_acc[1]), 64'd13);
        chk("rst_first_row", 64'(first_row[1]), 64'd2);
        chk("rst_first_col", 64'(first_col[1]), 64'd2);
        chk("rst_vcount_gate1", 64'(vcount[1]), 64'd3);
        chk("rst_vcount_gate0", 64'(vcount[0]), 64'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/window_line_buffer.md
Name: window_line_buffer

Overview:
- Parametrised K-row line buffer for the CNN convolution datapath. It sits between the pixel stream source and the K x K convolution window / MAC array.
- Accepts one pixel per in_valid beat in raster order. Emits one column of K vertically aligned pixels per accepted beat.
- Tracks (row, col) position so that out_valid marks only legal window positions.
- Adds over the previous single-size buffer:
  - generic kernel height and map size;
  - column gating;
  - frame re-sync;
  - start-of-window and end-of-frame markers.

Parameters:
- MAP_W, 28, pixels per row (>= K)
- MAP_H, 28, rows per frame (>= K)
- DATA_W, 16, pixel width in bits
- K, 5, kernel height = number of output taps (2..7)
- COL_GATE, 1, 1 = out_valid only when col >= K-1; 0 = valid for every column once row >= K-1 (legacy behaviour)

Ports:
- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- d_in  in  DATA_W  input pixel
- in_valid  in  1  pixel accept strobe; no backpressure
- in_sof  in  1  qualified by in_valid; this pixel is (row 0, col 0)
- d_out  out  K*DATA_W  tap column; slice j = bits [j*DATA_W +: DATA_W]; slice 0 = oldest row (r-K+1), slice K-1 = current pixel
- out_valid  out  1  d_out is a legal window column
- out_row  out  clog2(MAP_H)  row of the current pixel in d_out
- out_col  out  clog2(MAP_W)  column of the current pixel in d_out
- out_sow  out  1  first valid window of the frame (row K-1, col K-1, or col 0 if COL_GATE=0)
- out_eof  out  1  last pixel of the frame (row MAP_H-1, col MAP_W-1); asserted even if out_valid=0 never applies (it coincides with a valid beat)

Behaviour:
- Reset is synchronous active-high. Clock is clk; reset is rst.
- On rst:
  - col/row counters = 0;
  - all outputs = 0, including d_out;
  - line memories are NOT reset; row gating makes stale contents unobservable.
- Storage:
  - K-1 line memories mem[0..K-2], each MAP_W x DATA_W, addressed by col.
  - mem[j] holds row r-(K-1-j).
- Accept beat (in_valid=1), all in the same edge:
  - d_out slice j <= mem[j][col] for j < K-1 (pre-write value);
  - d_out slice K-1 <= d_in;
  - mem[j][col] <= mem[j+1][col] for j < K-2;
  - mem[K-2][col] <= d_in.
- Latency: exactly 1 cycle from accept to out_valid/d_out.
- Position counters:
  - col increments per accept and wraps MAP_W-1 -> 0 with row++;
  - row wraps MAP_H-1 -> 0 (automatic frame wrap);
  - out_row/out_col report the pre-increment position.
- out_valid <= in_valid && row >= K-1 && (COL_GATE==0 || col >= K-1).
- in_sof:
  - the beat is treated as position (0,0);
  - counters become col=1, row=0;
  - takes effect mid-row or mid-frame (re-sync); no other effect.
- in_valid=0:
  - counters and memories hold;
  - d_out, out_row, out_col hold;
  - out_valid, out_sow, out_eof = 0 next cycle.
- New frame: rows 0..K-2 produce no out_valid even though memories hold the previous frame.
- Reset mid-frame: the next accepted pixel is (0,0). No out_valid until row K-1 is reached again.
- Pointer logic and the counters are the only state; there is no FSM beyond the counters.
- Widths: counters are sized clog2 of the dimension. Compare with dimension-1 constants; never rely on natural overflow.

Decomposition:
- Shared package cnn_pkg:
  - DATA_W default;
  - a clog2 helper function;
  - a tap-slice index function.
- One sub-module, line_mem: simple single-port, read-before-write, MAP_W x DATA_W, no reset. Instantiated K-1 times via generate so synthesis maps it to distributed or block RAM.

Test Plan (MAP_W=5, MAP_H=5, K=3, DATA_W=8, pixel = row*16+col):
- Continuous frame, COL_GATE=1:
  - first out_valid 1 cycle after pixel (2,2) is accepted;
  - d_out = {0x22, 0x12, 0x02} (slice 2..0), out_sow=1;
  - exactly 9 valid beats per frame;
  - out_eof on (4,4) with d_out = {0x44, 0x34, 0x24}.
- COL_GATE=0, same stimulus:
  - first out_valid at (2,0) with d_out = {0x20, 0x10, 0x00};
  - 15 valid beats per frame.
- Random in_valid gaps (~40% idle):
  - sequence of valid d_out values identical to the continuous case;
  - outputs hold during gaps; out_valid=0 in idle cycles.
- Two back-to-back frames, second frame values +0x80:
  - no out_valid for rows 0-1 of frame 2;
  - first frame-2 window = {0xA2, 0x92, 0x82}, with no leakage of frame-1 data.
- in_sof asserted at frame 1 position (3,1):
  - counters re-sync; that pixel reports out_row=0, out_col=0;
  - subsequent windows are aligned to the new origin.
- rst pulsed for 1 cycle at (3,3):
  - all outputs 0 on the next cycle;
  - the following 15 accepts produce no out_valid until new row 2, col 2.
